// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store into a word-aligned memory request,
// holds the core with stall while the access is outstanding, and extends load results.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] load_data_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [3:0]  dmem_be_r;
    logic [31:0] dmem_wdata_r;
    logic [2:0]  func3_r;
    logic [1:0]  offset_r;

    logic        access_s;
    logic        legal_s;
    logic        aligned_s;
    logic        start_s;
    logic        fault_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Select the addressed byte/half of the returned word and sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'd0, b};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = word;
        endcase
    endfunction

    // Decode legality, alignment, lane enables and replicated write data.
    always_comb begin
        access_s  = mem_read | mem_write;
        legal_s   = 1'b0;
        aligned_s = 1'b0;
        be_s      = 4'b1111;
        wdata_s   = store_data;
        case (func3)
            3'b000: begin
                legal_s   = 1'b1;
                aligned_s = 1'b1;
                be_s      = 4'b0001 << address[1:0];
                wdata_s   = {4{store_data[7:0]}};
            end
            3'b001: begin
                legal_s   = 1'b1;
                aligned_s = ~address[0];
                be_s      = address[1] ? 4'b1100 : 4'b0011;
                wdata_s   = {2{store_data[15:0]}};
            end
            3'b010: begin
                legal_s   = 1'b1;
                aligned_s = (address[1:0] == 2'b00);
                be_s      = 4'b1111;
                wdata_s   = store_data;
            end
            3'b100: begin
                legal_s   = ~mem_write;
                aligned_s = 1'b1;
            end
            3'b101: begin
                legal_s   = ~mem_write;
                aligned_s = ~address[0];
            end
            default: begin
                legal_s   = 1'b0;
                aligned_s = 1'b0;
            end
        endcase
        // Reads always fetch the whole word; lane selection happens on return.
        if (!mem_write) begin
            be_s = 4'b1111;
        end else begin
            be_s = be_s;
        end
        start_s = (state_r == IDLE) && access_s && legal_s && aligned_s;
        fault_s = (state_r == IDLE) && access_s && !(legal_s && aligned_s);
    end

    // Request FSM with registered memory-side outputs and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            load_data_r  <= 32'd0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_be_r    <= 4'd0;
            dmem_wdata_r <= 32'd0;
            func3_r      <= 3'd0;
            offset_r     <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= mem_write;
                        dmem_addr_r  <= {address[31:2], 2'b00};
                        dmem_be_r    <= be_s;
                        dmem_wdata_r <= wdata_s;
                        func3_r      <= func3;
                        offset_r     <= address[1:0];
                        state_r      <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        dmem_req_r <= 1'b0;
                        if (!dmem_we_r) begin
                            load_data_r <= extend_load(func3_r, offset_r, dmem_rdata);
                        end else begin
                            load_data_r <= load_data_r;
                        end
                        state_r <= DONE;
                    end else begin
                        state_r <= REQ;
                    end
                end
                // The finishing instruction's strobe is still up here; never re-issue it.
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    dmem_req_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign stall      = start_s | (state_r == REQ);
    assign fault      = fault_s;
    assign load_data  = load_data_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_be    = dmem_be_r;
    assign dmem_wdata = dmem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected requests/results are queued when an
// access is driven and popped when the DUT raises dmem_req.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] address, store_data;
    logic [31:0] load_data;
    logic        stall, fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] load;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_load;

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .address(address), .store_data(store_data),
        .load_data(load_data), .stall(stall), .fault(fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_fault", 32'(fault), 32'd0);
        check("idle_req", 32'(dmem_req), 32'd0);
    endtask

    // One complete access; dmem_ready is deliberately high in the accept cycle (must be ignored).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                          input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_load);
        exp_t e;
        int   stalls, reqs, k;
        bit   done;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; func3 = f3; address = a;
        store_data = sd; dmem_rdata = rdat; dmem_ready = 1'b1;
        e.addr = e_addr; e.be = e_be; e.wdata = e_wdata; e.we = wr; e.load = e_load;
        sb_q.push_back(e);
        #1;
        check("accept_stall", 32'(stall), 32'd1);
        check("accept_fault", 32'(fault), 32'd0);
        check("accept_req", 32'(dmem_req), 32'd0);
        stalls = stall ? 1 : 0;
        reqs = 0; k = 0; done = 1'b0;
        while (!done && k < waits + 8) begin
            @(posedge clk); #1;
            dmem_ready = (k == waits);
            #1;
            if (dmem_req) begin
                if (reqs == 0) begin
                    e = sb_q.pop_front();
                    check("req_addr", dmem_addr, e.addr);
                    check("req_be", 32'(dmem_be), 32'(e.be));
                    check("req_we", 32'(dmem_we), 32'(e.we));
                    if (e.we) check("req_wdata", dmem_wdata, e.wdata);
                end else begin
                    check("hold_addr", dmem_addr, e.addr);
                    check("hold_be", 32'(dmem_be), 32'(e.be));
                end
                reqs++;
            end else begin
                done = 1'b1;
            end
            if (stall) stalls++;
            k++;
        end
        check("req_cycles", 32'(reqs), 32'(waits + 1));
        check("stall_cycles", 32'(stalls), 32'(waits + 2));
        check("load_data", load_data, e_load);
        last_load = e_load;
    endtask

    task automatic fault_case(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; func3 = f3; address = a; store_data = 32'h1234_5678;
        #1;
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_stall", 32'(stall), 32'd0);
        check("fault_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #2;
        check("fault_stay_idle", 32'(fault), 32'd1);
        check("fault_req_next", 32'(dmem_req), 32'd0);
        check("fault_load_kept", load_data, last_load);
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0;
        address = 32'd0; store_data = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        last_load = 32'd0;
        #2;
        check("rst_load_data", load_data, 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'd0, 32'hDEADBEEF);
        go_idle();
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, 0, 32'h100, 4'b1111, 32'd0, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, 1, 32'h100, 4'b1111, 32'd0, 32'h00000080);
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80017FFF, 0, 32'h100, 4'b1111, 32'd0, 32'hFFFF8001);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80017FFF, 0, 32'h100, 4'b1111, 32'd0, 32'h00008001);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'd0, 3, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00008001);
        go_idle();

        fault_case(1'b1, 1'b0, 3'b010, 32'h101);
        fault_case(1'b0, 1'b1, 3'b001, 32'h003);
        fault_case(1'b1, 1'b0, 3'b011, 32'h000);

        // Back-to-back byte stores; the second also raises mem_read, which the write overrides.
        access(1'b0, 1'b1, 3'b000, 32'h11, 32'h10, 32'd0, 0, 32'h10, 4'b0010, 32'h10101010, 32'h00008001);
        access(1'b1, 1'b1, 3'b000, 32'h12, 32'h20, 32'd0, 0, 32'h10, 4'b0100, 32'h20202020, 32'h00008001);
        go_idle();

        // Reset in the middle of an outstanding request.
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; address = 32'h40; dmem_ready = 1'b0;
        @(posedge clk); #2;
        check("mid_req_up", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'd0);
        check("mid_rst_load", load_data, 32'd0);
        check("mid_rst_addr", dmem_addr, 32'd0);
        check("mid_rst_be", 32'(dmem_be), 32'd0);
        check("mid_rst_wdata", dmem_wdata, 32'd0);
        check("mid_rst_we", 32'(dmem_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = 1'b1;
            @(posedge clk); #2;
            check("post_rst_req", 32'(dmem_req), 32'd0);
            check("post_rst_stall", 32'(stall), 32'd0);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
